pipe_csel_addsub: RTL and testbench

Parametrised, pipelined carry-select adder/subtractor. It is the next generation of the fixed 9-bit square-root carry-select adder used in the Radix-4 Booth MACC datapath. Operands are split into SEG-bit segments, and each segment is resolved in its own pipeline stage, with a registered carry between stages. A valid/ready handshake allows back-pressure from the downstream accumulator.

---
 rtl/pipe_csel_addsub_if.sv | 24 ++
 rtl/pipe_csel_addsub.sv | 122 ++++++++++++
 tb/tb_pipe_csel_addsub.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_csel_addsub_if.sv
// Handshake bundle for pipe_csel_addsub: operand side (in_*) and result side (out_*).
// The slave modport is the adder; the master modport is the surrounding datapath.
interface pipe_csel_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/pipe_csel_addsub.sv
// Pipelined carry-select adder/subtractor: one SEG-bit segment per stage, registered
// carry between stages, operands skewed forward and finished segments de-skewed behind.
module pipe_csel_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic              clk,
    input  logic              rst,
    pipe_csel_addsub_if.slave bus
);
    localparam int NSEG = WIDTH / SEG;

    logic             w_en;
    logic [WIDTH-1:0] w_binv;

    logic             r_vld_in;
    logic             r_sub_in;
    logic [WIDTH-1:0] r_a_in;
    logic [WIDTH-1:0] r_b_in;

    assign w_en         = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_en;
    assign w_binv       = bus.in_b ^ {WIDTH{bus.in_sub}};

    // Operand capture: B is pre-inverted for subtraction, in_sub doubles as carry-in
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_in <= 1'b0;
            r_sub_in <= 1'b0;
            r_a_in   <= '0;
            r_b_in   <= '0;
        end else if (w_en) begin
            r_vld_in <= bus.in_valid;
            r_sub_in <= bus.in_sub;
            r_a_in   <= bus.in_a;
            r_b_in   <= w_binv;
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_st
        logic                   w_pvld;
        logic                   w_cin;
        logic                   w_psub;
        logic                   w_cout;
        logic [SEG-1:0]         w_a;
        logic [SEG-1:0]         w_b;
        logic [SEG-1:0]         w_seg;
        logic [SEG:0]           w_s0;
        logic [SEG:0]           w_s1;
        logic [(k+1)*SEG-1:0]   w_sumnx;

        logic                   r_vld;
        logic                   r_c;
        logic                   r_sub;
        logic [(k+1)*SEG-1:0]   r_sum;

        if (k == 0) begin : g_head
            assign w_pvld  = r_vld_in;
            assign w_cin   = r_sub_in;
            assign w_psub  = r_sub_in;
            assign w_a     = r_a_in[SEG-1:0];
            assign w_b     = r_b_in[SEG-1:0];
            assign w_sumnx = w_seg;
        end else begin : g_body
            assign w_pvld  = g_st[k-1].r_vld;
            assign w_cin   = g_st[k-1].r_c;
            assign w_psub  = g_st[k-1].r_sub;
            assign w_a     = g_st[k-1].g_fwd.r_opa[SEG-1:0];
            assign w_b     = g_st[k-1].g_fwd.r_opb[SEG-1:0];
            assign w_sumnx = {w_seg, g_st[k-1].r_sum};
        end

        // Both candidates are formed in parallel; the registered carry only picks one
        assign w_s0 = {1'b0, w_a} + {1'b0, w_b};
        assign w_s1 = {1'b0, w_a} + {1'b0, w_b} + {{SEG{1'b0}}, 1'b1};
        assign {w_cout, w_seg} = w_cin ? w_s1 : w_s0;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_sub <= 1'b0;
                r_sum <= '0;
            end else if (w_en) begin
                r_vld <= w_pvld;
                r_c   <= w_cout;
                r_sub <= w_psub;
                r_sum <= w_sumnx;
            end
        end

        if (k < NSEG - 1) begin : g_fwd
            localparam int OPW = WIDTH - (k + 1) * SEG;
            logic [OPW-1:0] w_nxa;
            logic [OPW-1:0] w_nxb;
            logic [OPW-1:0] r_opa;
            logic [OPW-1:0] r_opb;

            if (k == 0) begin : g_src0
                assign w_nxa = r_a_in[WIDTH-1:SEG];
                assign w_nxb = r_b_in[WIDTH-1:SEG];
            end else begin : g_srck
                assign w_nxa = g_st[k-1].g_fwd.r_opa[OPW+SEG-1:SEG];
                assign w_nxb = g_st[k-1].g_fwd.r_opb[OPW+SEG-1:SEG];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_opa <= '0;
                    r_opb <= '0;
                end else if (w_en) begin
                    r_opa <= w_nxa;
                    r_opb <= w_nxb;
                end
            end
        end
    end

    // Extension bit: ea[WIDTH]=0 and eb[WIDTH]=in_sub, so it reduces to sub ^ final carry
    assign bus.out_valid = g_st[NSEG-1].r_vld;
    assign bus.out_sum   = {g_st[NSEG-1].r_sub ^ g_st[NSEG-1].r_c, g_st[NSEG-1].r_sum};
endmodule

// File: tb/tb_pipe_csel_addsub.sv
// Scenario bench for pipe_csel_addsub (WIDTH=16, SEG=4): results are matched in order
// against a queue of expected values filled as each operand set is accepted.
module tb_pipe_csel_addsub;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_csel_addsub_if #(.WIDTH(W)) bus();
    pipe_csel_addsub #(.WIDTH(W), .SEG(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [W:0] q_exp[$];
    logic [W:0] e;

    logic       s_acc, s_ov, s_ir, s_took;
    logic [W:0] s_sum;

    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub);
        ref_op = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic ordy);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_sub    = sub;
        bus.out_ready = ordy;
    endtask

    // One clock: sample at the falling edge, record an accepted op, return #1 past the rise
    task automatic step(input logic [W:0] exp_v);
        @(negedge clk);
        s_ov   = bus.out_valid;
        s_sum  = bus.out_sum;
        s_ir   = bus.in_ready;
        s_acc  = bus.in_valid && bus.in_ready;
        s_took = bus.out_valid && bus.out_ready;
        if (s_acc) q_exp.push_back(exp_v);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        step('0);
        step('0);
        rst = 1'b0;
        step('0);
        total++; if (s_ov !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b want=0", s_ov); end
        total++; if (s_sum !== 17'h0) begin bad++; $display("FAIL reset_sum: got=%h want=00000", s_sum); end
        total++; if (s_ir !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%b want=1", s_ir); end
    endtask

    task automatic test_add_basic();
        drive(1'b1, 16'd1, 16'd1, 1'b0, 1'b1);
        step(17'h00002);
        total++; if (s_acc !== 1'b1) begin bad++; $display("FAIL basic_accept: got=%b want=1", s_acc); end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        for (int k = 2; k <= 8; k++) begin
            step('0);
            total++;
            if (s_ov !== (k == 6)) begin
                bad++; $display("FAIL basic_latency: step %0d out_valid got=%b want=%b", k, s_ov, (k == 6));
            end
            if (s_took) begin
                total++;
                if (q_exp.size() == 0) begin bad++; $display("FAIL basic_extra: got=%h want=none", s_sum); end
                else begin
                    e = q_exp.pop_front();
                    if (s_sum !== e) begin bad++; $display("FAIL basic_sum: got=%h want=%h", s_sum, e); end
                end
            end
        end
    endtask

    task automatic test_boundary_sub();
        logic [W-1:0] ta[6] = '{16'hFFFF, 16'hFFFF, 16'd4, 16'd8, 16'd0, 16'd0};
        logic [W-1:0] tb[6] = '{16'h0001, 16'hFFFF, 16'd3, 16'd8, 16'd1, 16'hFFFF};
        logic         ts[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [W:0]   te[6] = '{17'h10000, 17'h1FFFE, 17'h00001, 17'h00000, 17'h1FFFF, 17'h10001};
        int i = 0;
        for (int c = 0; c < 40 && (i < 6 || q_exp.size() > 0); c++) begin
            if (i < 6) begin
                drive(1'b1, ta[i], tb[i], ts[i], 1'b1);
                step(te[i]);
            end else begin
                drive(1'b0, '0, '0, 1'b0, 1'b1);
                step('0);
            end
            if (s_acc) i++;
            if (s_took) begin
                total++;
                if (q_exp.size() == 0) begin bad++; $display("FAIL bound_extra: got=%h want=none", s_sum); end
                else begin
                    e = q_exp.pop_front();
                    if (s_sum !== e) begin bad++; $display("FAIL bound_sum: got=%h want=%h", s_sum, e); end
                end
            end
        end
        total++; if (q_exp.size() != 0 || i != 6) begin bad++; $display("FAIL bound_drain: left=%0d issued=%0d want 0/6", q_exp.size(), i); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        logic         sub;
        logic [W:0]   held = '0;
        int i = 0;
        int nout = 0;
        for (int c = 0; c < 60 && (i < 8 || q_exp.size() > 0); c++) begin
            a   = 16'h0249 + 16'(i) * 16'h0321;
            b   = 16'h0136 + 16'(i) * 16'h0107;
            sub = i[0];
            drive(i < 8, a, b, sub, !(c >= 6 && c < 9));
            step((i == 0) ? 17'h0037F : ref_op(a, b, sub));
            if (s_acc) i++;
            if (c >= 6 && c < 9) begin
                total++; if (s_ir !== 1'b0) begin bad++; $display("FAIL stall_in_ready: cyc %0d got=%b want=0", c, s_ir); end
                if (c == 6) held = s_sum;
                else begin
                    total++; if (s_sum !== held) begin bad++; $display("FAIL stall_hold: cyc %0d got=%h want=%h", c, s_sum, held); end
                end
            end
            if (s_took) begin
                nout++;
                total++;
                if (q_exp.size() == 0) begin bad++; $display("FAIL b2b_extra: got=%h want=none", s_sum); end
                else begin
                    e = q_exp.pop_front();
                    if (s_sum !== e) begin bad++; $display("FAIL b2b_sum: got=%h want=%h", s_sum, e); end
                end
            end
        end
        total++; if (nout != 8) begin bad++; $display("FAIL b2b_count: got=%0d want=8", nout); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         sub, v;
        int i = 0;
        int nout = 0;
        for (int c = 0; c < 20000 && (i < 1000 || q_exp.size() > 0); c++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            sub = $urandom_range(0, 1) == 1;
            v   = (i < 1000) && ($urandom_range(0, 99) < 80);
            drive(v, a, b, sub, $urandom_range(0, 99) < 75);
            step(ref_op(a, b, sub));
            if (s_acc) i++;
            if (s_took) begin
                nout++;
                total++;
                if (q_exp.size() == 0) begin bad++; $display("FAIL rand_extra: got=%h want=none", s_sum); end
                else begin
                    e = q_exp.pop_front();
                    if (s_sum !== e) begin bad++; $display("FAIL rand_sum: got=%h want=%h", s_sum, e); end
                end
            end
        end
        total++; if (nout != 1000) begin bad++; $display("FAIL rand_count: got=%0d want=1000", nout); end
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 16'h1000 + 16'(j), 16'h0100, 1'b0, 1'b1);
            step(ref_op(16'h1000 + 16'(j), 16'h0100, 1'b0));
        end
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        step('0);
        rst = 1'b0;
        q_exp.delete();
        step('0);
        total++; if (s_ov !== 1'b0) begin bad++; $display("FAIL rmid_valid: got=%b want=0", s_ov); end
        total++; if (s_sum !== 17'h0) begin bad++; $display("FAIL rmid_sum: got=%h want=00000", s_sum); end
        drive(1'b1, 16'd2, 16'd3, 1'b0, 1'b1);
        step(17'h00005);
        total++; if (s_acc !== 1'b1 || s_ov !== 1'b0) begin bad++; $display("FAIL rmid_accept: acc=%b valid=%b want 1/0", s_acc, s_ov); end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        for (int k = 2; k <= 8; k++) begin
            step('0);
            total++;
            if (s_ov !== (k == 6)) begin
                bad++; $display("FAIL rmid_stale: step %0d out_valid got=%b want=%b", k, s_ov, (k == 6));
            end
            if (s_took) begin
                total++;
                if (q_exp.size() == 0) begin bad++; $display("FAIL rmid_extra: got=%h want=none", s_sum); end
                else begin
                    e = q_exp.pop_front();
                    if (s_sum !== e) begin bad++; $display("FAIL rmid_sum2: got=%h want=%h", s_sum, e); end
                end
            end
        end
    endtask

    task automatic test_bubbles();
        logic v, ev;
        logic [W-1:0] a, b;
        for (int k = 1; k <= 20; k++) begin
            v  = (k <= 12) && (k % 2 == 1);
            ev = (k > 5) && (k - 5 <= 12) && ((k - 5) % 2 == 1);
            a  = 16'h0F00 + 16'(k * 37);
            b  = 16'h00F0 + 16'(k * 11);
            drive(v, a, b, k[1], 1'b1);
            step(ref_op(a, b, k[1]));
            total++;
            if (s_ov !== ev) begin bad++; $display("FAIL bubble_valid: step %0d got=%b want=%b", k, s_ov, ev); end
            if (s_took) begin
                total++;
                if (q_exp.size() == 0) begin bad++; $display("FAIL bubble_extra: got=%h want=none", s_sum); end
                else begin
                    e = q_exp.pop_front();
                    if (s_sum !== e) begin bad++; $display("FAIL bubble_sum: got=%h want=%h", s_sum, e); end
                end
            end
        end
        total++; if (q_exp.size() != 0) begin bad++; $display("FAIL bubble_drain: left=%0d want=0", q_exp.size()); end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_boundary_sub();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_bubbles();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
